stream_demux: RTL and testbench

//   Registered, parametrised 1-to-NUM_CH stream demultiplexer. It is the successor of the

---
 rtl/stream_demux.sv | 84 ++++++++
 tb/tb_stream_demux.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// stream_demux: registered 1-to-NUM_CH valid/ready demux; the select locks for a whole packet.
// Define STREAM_DEMUX_PKTCNT_EN to add saturating per-channel packet counters on pkt_cnt.
module stream_demux #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_last,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH-1:0]        out_last,
  output logic                     err_sel
`ifdef STREAM_DEMUX_PKTCNT_EN
  ,
  output logic [NUM_CH*16-1:0]     pkt_cnt
`endif
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t                  r_state, w_state_nxt;
  logic [SEL_W-1:0]        r_lock_sel, w_ch;
  logic [NUM_CH-1:0]       r_full, r_last, w_wr;
  logic [NUM_CH*DATA_W-1:0] r_data;
  logic                    r_err, w_in_range, w_acc;
  always_comb begin
    w_ch        = r_state == LOCKED ? r_lock_sel : in_sel;
    w_in_range  = 32'(w_ch) < NUM_CH;
    in_ready    = rst_n & (w_in_range ? (!r_full[w_ch] | out_ready[w_ch]) : 1'b1);
    w_acc       = in_valid & in_ready;
    w_wr        = '0;
    if (w_acc & w_in_range) w_wr[w_ch] = 1'b1;
    w_state_nxt = r_state;
    if (w_acc) w_state_nxt = in_last ? IDLE : LOCKED;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_lock_sel <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_acc && !in_last) r_lock_sel <= in_sel;
    end
  end
  // A write wins over a drain in the same cycle, so the slot refills without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
      r_last <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_acc & !w_in_range;
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr[c]) begin
          r_full[c]                 <= 1'b1;
          r_last[c]                 <= in_last;
          r_data[c*DATA_W +: DATA_W] <= in_data;
        end else if (out_ready[c]) begin
          r_full[c] <= 1'b0;
        end
      end
    end
  end
  assign out_valid = r_full;
  assign out_last  = r_last;
  assign out_data  = r_data;
  assign err_sel   = r_err;
`ifdef STREAM_DEMUX_PKTCNT_EN
  for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
    logic [15:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else if (r_full[c] && out_ready[c] && r_last[c] && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
    assign pkt_cnt[c*16 +: 16] = r_cnt;
  end
`endif
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: directed bench for stream_demux with a per-cycle reference model (4-channel DUT)
// and literal checks on a 3-channel DUT for out-of-range selects.
module tb_stream_demux;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic [1:0]  in_sel = '0;
  logic        in_ready, err_sel;
  logic [31:0] out_data;
  logic [3:0]  out_valid, out_last;
  logic [3:0]  out_ready = 4'hF;
  logic [7:0]  b_data = '0;
  logic        b_valid = 1'b0, b_last = 1'b0;
  logic [1:0]  b_sel = '0;
  logic        b_in_ready, b_err;
  logic [23:0] b_out_data;
  logic [2:0]  b_out_valid, b_out_last;
  logic [2:0]  b_out_ready = 3'b111;
  int          errs = 0, checks = 0;
`ifdef STREAM_DEMUX_PKTCNT_EN
  logic [63:0] pkt_cnt;
  logic [47:0] b_pkt_cnt;
`endif

  stream_demux #(.DATA_W(8), .NUM_CH(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_last(in_last), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .err_sel(err_sel)
`ifdef STREAM_DEMUX_PKTCNT_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );

  stream_demux #(.DATA_W(8), .NUM_CH(3), .SEL_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_in_ready),
    .in_sel(b_sel), .in_last(b_last), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_last(b_out_last), .err_sel(b_err)
`ifdef STREAM_DEMUX_PKTCNT_EN
    , .pkt_cnt(b_pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Reference model: each channel is a one-deep holding slot; a packet's channel is fixed by its first beat.
  bit       m_full[4];
  bit       m_last[4];
  bit [7:0] m_data[4];
  int       m_cnt[4];
  bit       m_in_pkt = 0;
  int       m_pkt_ch = 0;
  bit       m_err = 0;

  function automatic int exp_ch();
    return m_in_pkt ? m_pkt_ch : int'(in_sel);
  endfunction

  function automatic bit exp_rdy();
    int ch = exp_ch();
    if (!rst_n) return 1'b0;
    return ch >= 4 ? 1'b1 : (!m_full[ch] || out_ready[ch]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin
        m_full[c] = 0; m_last[c] = 0; m_data[c] = '0; m_cnt[c] = 0;
      end
      m_in_pkt = 0; m_pkt_ch = 0; m_err = 0;
    end else begin
      int ch;
      bit acc;
      ch  = exp_ch();
      acc = in_valid && exp_rdy();
      for (int c = 0; c < 4; c++)
        if (m_full[c] && out_ready[c]) begin
          if (m_last[c] && m_cnt[c] < 65535) m_cnt[c]++;
          m_full[c] = 0;
        end
      m_err = acc && ch >= 4;
      if (acc && ch < 4) begin
        m_full[ch] = 1; m_data[ch] = in_data; m_last[ch] = in_last;
      end
      if (acc) begin
        m_in_pkt = !in_last;
        m_pkt_ch = ch;
      end
    end
  end

  always @(negedge clk) begin
    if ($time > 10) begin
      logic [3:0]  ev, el;
      logic [31:0] ed, ad;
      ev = '0; el = '0; ed = '0; ad = '0;
      for (int c = 0; c < 4; c++) begin
        ev[c] = m_full[c];
        el[c] = m_full[c] & m_last[c];
        if (m_full[c]) begin
          ed[c*8 +: 8] = m_data[c];
          ad[c*8 +: 8] = out_data[c*8 +: 8];
        end
      end
      chk("model in_ready", in_ready, exp_rdy());
      chk("model out_valid", out_valid, ev);
      chk("model out_last", out_last & out_valid, el);
      chk("model out_data", ad, ed);
      chk("model err_sel", err_sel, m_err);
`ifdef STREAM_DEMUX_PKTCNT_EN
      for (int c = 0; c < 4; c++) chk("model pkt_cnt", pkt_cnt[c*16 +: 16], m_cnt[c][15:0]);
`endif
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] s, input logic l);
    in_data = d; in_sel = s; in_last = l; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset with a beat offered
    in_valid = 1'b1;
    tick(); tick();
    mid();
    chk("rst out_valid", out_valid, 4'h0);
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst err_sel", err_sel, 1'b0);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    mid();
    chk("post-rst in_ready", in_ready, 1'b1);
    tick();
    // Single-beat route to channel 2
    send(8'hA5, 2'd2, 1'b1);
    mid();
    chk("single out_valid", out_valid, 4'b0100);
    chk("single out_data", out_data[23:16], 8'hA5);
    chk("single out_last", out_last, 4'b0100);
    tick(); mid();
    chk("single drained", out_valid, 4'h0);
    tick();
    // Lock: select changes mid-packet are ignored
    send(8'h11, 2'd1, 1'b0);
    mid();
    chk("lock b1 valid", out_valid, 4'b0010);
    chk("lock b1 data", out_data[15:8], 8'h11);
    chk("lock b1 last", out_last[1], 1'b0);
    tick();
    send(8'h22, 2'd3, 1'b0);
    mid();
    chk("lock b2 valid", out_valid, 4'b0010);
    chk("lock b2 data", out_data[15:8], 8'h22);
    tick();
    send(8'h33, 2'd3, 1'b1);
    mid();
    chk("lock b3 valid", out_valid, 4'b0010);
    chk("lock b3 data", out_data[15:8], 8'h33);
    chk("lock b3 last", out_last[1], 1'b1);
    tick();
    // Backpressure on channel 0
    out_ready = 4'b1110;
    send(8'h01, 2'd0, 1'b0);
    mid();
    chk("bp held valid", out_valid[0], 1'b1);
    tick();
    in_data = 8'h02; in_sel = 2'd0; in_last = 1'b1; in_valid = 1'b1;
    mid();
    chk("bp in_ready low", in_ready, 1'b0);
    chk("bp data stable", out_data[7:0], 8'h01);
    tick(); mid();
    chk("bp in_ready low 2", in_ready, 1'b0);
    chk("bp data stable 2", out_data[7:0], 8'h01);
    tick();
    out_ready = 4'hF;
    mid();
    chk("bp in_ready release", in_ready, 1'b1);
    chk("bp first beat", out_data[7:0], 8'h01);
    tick();
    in_valid = 1'b0;
    mid();
    chk("bp second beat", out_data[7:0], 8'h02);
    chk("bp second last", out_last[0] & out_valid[0], 1'b1);
    tick(); mid();
    chk("bp empty", out_valid, 4'h0);
    tick();
    // Out-of-range select on the 3-channel instance
    b_data = 8'hE1; b_sel = 2'd3; b_last = 1'b0; b_valid = 1'b1;
    mid();
    chk("bad in_ready b1", b_in_ready, 1'b1);
    tick();
    b_data = 8'hE2; b_last = 1'b1;
    mid();
    chk("bad in_ready b2", b_in_ready, 1'b1);
    chk("bad err b1", b_err, 1'b1);
    chk("bad out_valid b1", b_out_valid, 3'b000);
    tick();
    b_valid = 1'b0;
    mid();
    chk("bad err b2", b_err, 1'b1);
    chk("bad out_valid b2", b_out_valid, 3'b000);
    tick(); mid();
    chk("bad err idle", b_err, 1'b0);
    tick();
    b_data = 8'h5A; b_sel = 2'd0; b_last = 1'b1; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    mid();
    chk("good after bad valid", b_out_valid, 3'b001);
    chk("good after bad data", b_out_data[7:0], 8'h5A);
    tick();
    // Mid-packet reset, then the first beat starts a new packet
    send(8'h77, 2'd2, 1'b0);
    mid();
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 4'h0);
    chk("midrst in_ready", in_ready, 1'b0);
`ifdef STREAM_DEMUX_PKTCNT_EN
    chk("midrst pkt_cnt", pkt_cnt, 64'h0);
`endif
    tick();
    rst_n = 1'b1;
    send(8'h44, 2'd0, 1'b1);
    mid();
    chk("post-rst new packet", out_valid, 4'b0001);
    chk("post-rst data", out_data[7:0], 8'h44);
    tick();
    send(8'hC1, 2'd1, 1'b1);
    send(8'hC2, 2'd1, 1'b1);
    send(8'hC3, 2'd1, 1'b1);
    tick(); tick();
`ifdef STREAM_DEMUX_PKTCNT_EN
    mid();
    chk("pkt_cnt ch1", pkt_cnt[31:16], 16'd3);
    chk("pkt_cnt ch0", pkt_cnt[15:0], 16'd1);
`endif
    // Back-to-back beats through a stalled-then-released channel 3
    out_ready = 4'b0111;
    in_sel = 2'd3; in_last = 1'b0; in_data = 8'h90; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (in_ready) in_data = in_data + 8'h1;
      if (i == 2) out_ready = 4'hF;
      if (i == 4) in_last = 1'b1;
    end
    in_valid = 1'b0;
    tick(); tick(); tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
